// File: rtl/mips_pkg.sv
// Shared constants for the 5-stage MIPS pipeline: bubble encoding, register
// zero and the Tnew encodings used by the stall/forward unit.
package mips_pkg;

  // All-zero word is "sll $0,$0,0", the canonical nop.
  localparam logic [31:0] NOP_INSTR = 32'h0;

  // Largest legal Tnew at E entry; anything larger is clamped to this.
  localparam int TNEW_MAX = 2;

  // Tnew at E entry: result already available, ALU result next stage, load.
  localparam int TNEW_NONE = 0;
  localparam int TNEW_ALU  = 1;
  localparam int TNEW_LOAD = 2;

  // Writes to $0 are architecturally discarded.
  localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/de_em_pipe_if.sv
// Signal bundle between the D/E/M pipeline registers and the surrounding
// core: D-stage inputs, E-stage results, and the registered E/M outputs.
interface de_em_pipe_if #(
  parameter int DW = 32,
  parameter int TW = 2
);

  logic          stall;
  logic          flush_e;
  logic [DW-1:0] instr_d;
  logic [DW-1:0] pc_d;
  logic [DW-1:0] rs_d;
  logic [DW-1:0] rt_d;
  logic [4:0]    A1_D;
  logic [4:0]    A2_D;
  logic [4:0]    A3_D;
  logic          regwrite_d;
  logic [TW-1:0] tnew_d;
  logic [DW-1:0] alu_e;
  logic [DW-1:0] rt_fwd_e;

  logic [DW-1:0] instr_e;
  logic [DW-1:0] pc_e;
  logic [DW-1:0] rs_e;
  logic [DW-1:0] rt_e;
  logic [4:0]    A1_E;
  logic [4:0]    A2_E;
  logic [4:0]    A3_E;
  logic          regwrite_e;
  logic [TW-1:0] tnew_E;
  logic [DW-1:0] instr_m;
  logic [DW-1:0] pc_m;
  logic [DW-1:0] alu_m;
  logic [DW-1:0] rt_m;
  logic [4:0]    A2_M;
  logic [4:0]    A3_M;
  logic          regwrite_m;
  logic [TW-1:0] tnew_M;
  logic [15:0]   bubble_cnt;

  // Core side: drives D/E-stage values, observes pipeline register state.
  modport master (
    output stall, flush_e, instr_d, pc_d, rs_d, rt_d, A1_D, A2_D, A3_D,
           regwrite_d, tnew_d, alu_e, rt_fwd_e,
    input  instr_e, pc_e, rs_e, rt_e, A1_E, A2_E, A3_E, regwrite_e, tnew_E,
           instr_m, pc_m, alu_m, rt_m, A2_M, A3_M, regwrite_m, tnew_M,
           bubble_cnt
  );

  // Pipeline register side.
  modport slave (
    input  stall, flush_e, instr_d, pc_d, rs_d, rt_d, A1_D, A2_D, A3_D,
           regwrite_d, tnew_d, alu_e, rt_fwd_e,
    output instr_e, pc_e, rs_e, rt_e, A1_E, A2_E, A3_E, regwrite_e, tnew_E,
           instr_m, pc_m, alu_m, rt_m, A2_M, A3_M, regwrite_m, tnew_M,
           bubble_cnt
  );

endinterface

// File: rtl/pipe_field_reg.sv
// Generic pipeline field register: synchronous active-low reset to zero,
// clear-to-constant (used for bubble insertion) and load enable.
module pipe_field_reg #(
  parameter int           W       = 8,
  parameter logic [W-1:0] CLR_VAL = '0
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic         clear,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  // Reset wins over clear, clear wins over load.
  always_ff @(posedge clk) begin
    if (!reset)
      q <= '0;
    else if (clear)
      q <= CLR_VAL;
    else if (load)
      q <= d;
  end

endmodule

// File: rtl/de_em_pipe.sv
// D->E and E->M pipeline registers with hazard metadata (addresses, write
// enable, Tnew). A stall or E flush replaces the instruction entering E with
// a bubble while M keeps advancing; bubbles are counted in a saturating
// performance counter.
module de_em_pipe
  import mips_pkg::*;
#(
  parameter int DW = 32,
  parameter int TW = 2
) (
  input logic         clk,
  input logic         reset,
  de_em_pipe_if.slave bus
);

  typedef struct packed {
    logic [DW-1:0] instr;
    logic [DW-1:0] rs;
    logic [DW-1:0] rt;
    logic [4:0]    a1;
    logic [4:0]    a2;
    logic [4:0]    a3;
    logic          regwrite;
    logic [TW-1:0] tnew;
  } de_t;

  typedef struct packed {
    logic [DW-1:0] instr;
    logic [DW-1:0] pc;
    logic [DW-1:0] alu;
    logic [DW-1:0] rt;
    logic [4:0]    a2;
    logic [4:0]    a3;
    logic          regwrite;
    logic [TW-1:0] tnew;
  } em_t;

  localparam int            DE_W      = $bits(de_t);
  localparam int            EM_W      = $bits(em_t);
  localparam logic [DE_W-1:0] DE_BUBBLE = {DW'(NOP_INSTR), {(DE_W-DW){1'b0}}};
  localparam logic [TW-1:0] TNEW_CAP  = TW'(TNEW_MAX);
  localparam logic [TW-1:0] TNEW_ZERO = TW'(TNEW_NONE);

  logic          bubble;
  de_t           de_next;
  de_t           de_q;
  logic [DW-1:0] pc_e_q;
  em_t           em_next;
  em_t           em_q;
  logic [15:0]   bubble_cnt_q;

  assign bubble = bus.stall | bus.flush_e;

  // Sanitise D-stage metadata: clamp illegal Tnew, drop writes to $0.
  always_comb begin
    de_next          = '0;
    de_next.instr    = bus.instr_d;
    de_next.rs       = bus.rs_d;
    de_next.rt       = bus.rt_d;
    de_next.a1       = bus.A1_D;
    de_next.a2       = bus.A2_D;
    de_next.a3       = bus.A3_D;
    de_next.regwrite = bus.regwrite_d && (bus.A3_D != REG_ZERO);
    de_next.tnew     = (bus.tnew_d > TNEW_CAP) ? TNEW_CAP : bus.tnew_d;
  end

  // Payload advancing from E to M; Tnew counts down and sticks at zero.
  always_comb begin
    em_next          = '0;
    em_next.instr    = de_q.instr;
    em_next.pc       = pc_e_q;
    em_next.alu      = bus.alu_e;
    em_next.rt       = bus.rt_fwd_e;
    em_next.a2       = de_q.a2;
    em_next.a3       = de_q.a3;
    em_next.regwrite = de_q.regwrite;
    em_next.tnew     = (de_q.tnew == TNEW_ZERO) ? TNEW_ZERO : de_q.tnew - 1'b1;
  end

  // D/E bundle: bubble clears everything except the PC.
  pipe_field_reg #(.W(DE_W), .CLR_VAL(DE_BUBBLE)) u_de_reg (
    .clk   (clk),
    .reset (reset),
    .load  (1'b1),
    .clear (bubble),
    .d     (de_next),
    .q     (de_q)
  );

  // The bubble keeps the PC of the held D instruction.
  pipe_field_reg #(.W(DW)) u_de_pc_reg (
    .clk   (clk),
    .reset (reset),
    .load  (1'b1),
    .clear (1'b0),
    .d     (bus.pc_d),
    .q     (pc_e_q)
  );

  // E/M bundle advances every cycle; there is no back-pressure into M.
  pipe_field_reg #(.W(EM_W)) u_em_reg (
    .clk   (clk),
    .reset (reset),
    .load  (1'b1),
    .clear (1'b0),
    .d     (em_next),
    .q     (em_q)
  );

  // Saturating count of bubbles loaded into E.
  always_ff @(posedge clk) begin
    if (!reset)
      bubble_cnt_q <= '0;
    else if (bubble && (bubble_cnt_q != 16'hFFFF))
      bubble_cnt_q <= bubble_cnt_q + 16'd1;
  end

  assign bus.instr_e    = de_q.instr;
  assign bus.pc_e       = pc_e_q;
  assign bus.rs_e       = de_q.rs;
  assign bus.rt_e       = de_q.rt;
  assign bus.A1_E       = de_q.a1;
  assign bus.A2_E       = de_q.a2;
  assign bus.A3_E       = de_q.a3;
  assign bus.regwrite_e = de_q.regwrite;
  assign bus.tnew_E     = de_q.tnew;
  assign bus.instr_m    = em_q.instr;
  assign bus.pc_m       = em_q.pc;
  assign bus.alu_m      = em_q.alu;
  assign bus.rt_m       = em_q.rt;
  assign bus.A2_M       = em_q.a2;
  assign bus.A3_M       = em_q.a3;
  assign bus.regwrite_m = em_q.regwrite;
  assign bus.tnew_M     = em_q.tnew;
  assign bus.bubble_cnt = bubble_cnt_q;

endmodule

// File: tb/tb_de_em_pipe.sv
// Scoreboard bench for de_em_pipe: directed vectors carry hand-computed E
// metadata; expected E/M/counter state is queued per clock and a negedge
// monitor pops and compares it against the registered outputs.
module tb_de_em_pipe;
  import mips_pkg::*;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] rs;
    logic [31:0] rt;
    logic [4:0]  a1;
    logic [4:0]  a2;
    logic [4:0]  a3;
    logic        regwrite;
    logic [1:0]  tnew;
  } e_t;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] alu;
    logic [31:0] rt;
    logic [4:0]  a2;
    logic [4:0]  a3;
    logic        regwrite;
    logic [1:0]  tnew;
  } m_t;

  typedef struct {
    e_t          e;
    m_t          m;
    logic [15:0] cnt;
  } exp_t;

  typedef struct {
    logic        rst_n;
    logic        stall;
    logic        flush;
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] rs;
    logic [31:0] rt;
    logic [4:0]  a1;
    logic [4:0]  a2;
    logic [4:0]  a3;
    logic        rw;
    logic [1:0]  tnew;
    logic [31:0] alu;
    logic [31:0] rtf;
    logic        exp_rw_e;
    logic [1:0]  exp_tnew_e;
  } vec_t;

  logic clk = 1'b0;
  logic reset;
  logic armed = 1'b0;
  int   compared = 0;
  int   mismatched = 0;

  exp_t        sb[$];
  exp_t        mon_x;
  e_t          mod_e;
  m_t          mod_m;
  logic [15:0] mod_cnt;

  de_em_pipe_if #(.DW(32), .TW(2)) bus ();

  de_em_pipe #(.DW(32), .TW(2)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // 10-time-unit clock.
  always #5 clk = ~clk;

  // Only start popping once the first active edge has happened.
  always @(posedge clk) armed <= 1'b1;

  // Hand-written Tnew countdown table (0 stays 0).
  function automatic logic [1:0] decTnew(input logic [1:0] t);
    case (t)
      2'd0:    return 2'd0;
      2'd1:    return 2'd0;
      2'd2:    return 2'd1;
      default: return 2'd2;
    endcase
  endfunction

  function automatic vec_t mkVec(
    input logic stall, input logic flush, input logic [31:0] instr,
    input logic [31:0] pc, input logic [31:0] rs, input logic [31:0] rt,
    input logic [4:0] a1, input logic [4:0] a2, input logic [4:0] a3,
    input logic rw, input logic [1:0] tnew, input logic [31:0] alu,
    input logic [31:0] rtf, input logic exp_rw_e, input logic [1:0] exp_tnew_e);
    vec_t v;
    v.rst_n = 1'b1; v.stall = stall; v.flush = flush; v.instr = instr;
    v.pc = pc; v.rs = rs; v.rt = rt; v.a1 = a1; v.a2 = a2; v.a3 = a3;
    v.rw = rw; v.tnew = tnew; v.alu = alu; v.rtf = rtf;
    v.exp_rw_e = exp_rw_e; v.exp_tnew_e = exp_tnew_e;
    return v;
  endfunction

  // Drive one clock's worth of inputs and queue the state expected after it.
  task automatic applyStimulus(input vec_t v);
    exp_t x;
    bus.stall      = v.stall;
    bus.flush_e    = v.flush;
    bus.instr_d    = v.instr;
    bus.pc_d       = v.pc;
    bus.rs_d       = v.rs;
    bus.rt_d       = v.rt;
    bus.A1_D       = v.a1;
    bus.A2_D       = v.a2;
    bus.A3_D       = v.a3;
    bus.regwrite_d = v.rw;
    bus.tnew_d     = v.tnew;
    bus.alu_e      = v.alu;
    bus.rt_fwd_e   = v.rtf;
    reset          = v.rst_n;
    if (!v.rst_n) begin
      x.e = '0;
      x.m = '0;
      x.cnt = 16'h0;
    end else begin
      x.m.instr    = mod_e.instr;
      x.m.pc       = mod_e.pc;
      x.m.alu      = v.alu;
      x.m.rt       = v.rtf;
      x.m.a2       = mod_e.a2;
      x.m.a3       = mod_e.a3;
      x.m.regwrite = mod_e.regwrite;
      x.m.tnew     = decTnew(mod_e.tnew);
      x.e          = '0;
      x.e.pc       = v.pc;
      x.e.regwrite = v.exp_rw_e;
      x.e.tnew     = v.exp_tnew_e;
      if (v.stall || v.flush) begin
        x.e.instr = NOP_INSTR;
        x.cnt = (mod_cnt == 16'hFFFF) ? 16'hFFFF : mod_cnt + 16'd1;
      end else begin
        x.e.instr = v.instr;
        x.e.rs    = v.rs;
        x.e.rt    = v.rt;
        x.e.a1    = v.a1;
        x.e.a2    = v.a2;
        x.e.a3    = v.a3;
        x.cnt     = mod_cnt;
      end
    end
    sb.push_back(x);
    mod_e   = x.e;
    mod_m   = x.m;
    mod_cnt = x.cnt;
    @(posedge clk);
    #1;
  endtask

  // Compare the observed E, M and counter state with one queued expectation.
  task automatic checkOutput(input exp_t x);
    e_t obs_e;
    m_t obs_m;
    obs_e.instr = bus.instr_e;  obs_e.pc = bus.pc_e;
    obs_e.rs = bus.rs_e;        obs_e.rt = bus.rt_e;
    obs_e.a1 = bus.A1_E;        obs_e.a2 = bus.A2_E;   obs_e.a3 = bus.A3_E;
    obs_e.regwrite = bus.regwrite_e;  obs_e.tnew = bus.tnew_E;
    obs_m.instr = bus.instr_m;  obs_m.pc = bus.pc_m;
    obs_m.alu = bus.alu_m;      obs_m.rt = bus.rt_m;
    obs_m.a2 = bus.A2_M;        obs_m.a3 = bus.A3_M;
    obs_m.regwrite = bus.regwrite_m;  obs_m.tnew = bus.tnew_M;
    compared += 3;
    if (obs_e !== x.e) begin
      mismatched++;
      $display("[TB] FAIL e_stage @%0t: got %h expected %h", $time, obs_e, x.e);
    end
    if (obs_m !== x.m) begin
      mismatched++;
      $display("[TB] FAIL m_stage @%0t: got %h expected %h", $time, obs_m, x.m);
    end
    if (bus.bubble_cnt !== x.cnt) begin
      mismatched++;
      $display("[TB] FAIL bubble_cnt @%0t: got %h expected %h", $time, bus.bubble_cnt, x.cnt);
    end
  endtask

  // Monitor: mid-cycle, pop the expectation for the edge just taken.
  always @(negedge clk) begin
    if (armed && sb.size() != 0) begin
      mon_x = sb.pop_front();
      checkOutput(mon_x);
    end
  end

  // Global time bound.
  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog: got timeout expected completion (%0d compared)", compared);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vec_t v;
    mod_e = '0; mod_m = '0; mod_cnt = 16'h0;

    // Reset with every input nonzero, including stall/flush: all outputs 0.
    v = mkVec(1, 1, 32'hFFFF_FFFF, 32'h1234_5678, 32'hAAAA_AAAA, 32'h5555_5555,
              5'd31, 5'd30, 5'd29, 1, 2'd3, 32'hDEAD_BEEF, 32'hCAFE_F00D, 0, 2'd0);
    v.rst_n = 1'b0;
    applyStimulus(v);
    applyStimulus(v);

    // addu $10,$8,$9: Tnew=1 at E entry.
    applyStimulus(mkVec(0, 0, 32'h0109_5021, 32'h0040_0000, 32'd5, 32'd7,
                        5'd8, 5'd9, 5'd10, 1, 2'(TNEW_ALU), 32'h0, 32'h0, 1, 2'd1));
    // lw $8,4($9): A3_E=8, tnew_E=2; addu result (12) flows to M.
    applyStimulus(mkVec(0, 0, 32'h8d28_0004, 32'h0040_0004, 32'h1000, 32'h2222,
                        5'd9, 5'd8, 5'd8, 1, 2'(TNEW_LOAD), 32'h0000_000C, 32'd7, 1, 2'd2));
    // Dependent addu $9,$8,$8 stalls: E bubble, M gets lw with tnew_M=1, cnt=1.
    applyStimulus(mkVec(1, 0, 32'h0108_4821, 32'h0040_0008, 32'h55, 32'h55,
                        5'd8, 5'd8, 5'd9, 1, 2'd1, 32'h0000_1004, 32'h2222, 0, 2'd0));
    // Same instruction re-presented without stall: captured normally.
    applyStimulus(mkVec(0, 0, 32'h0108_4821, 32'h0040_0008, 32'h77, 32'h77,
                        5'd8, 5'd8, 5'd9, 1, 2'd1, 32'h0, 32'h0, 1, 2'd1));
    // sw $9,0($8): no write, Tnew=0.
    applyStimulus(mkVec(0, 0, 32'had09_0000, 32'h0040_000C, 32'h77, 32'hEE,
                        5'd8, 5'd9, 5'd0, 0, 2'(TNEW_NONE), 32'h0000_00EE, 32'h77, 0, 2'd0));
    // Write to $0 is dropped: regwrite_e=0 even though regwrite_d=1.
    applyStimulus(mkVec(0, 0, 32'h0109_0021, 32'h0040_0010, 32'h3, 32'h4,
                        5'd8, 5'd9, 5'd0, 1, 2'd1, 32'h0000_1000, 32'hEE, 0, 2'd1));
    // Illegal Tnew=3 clamps to 2 in E.
    applyStimulus(mkVec(0, 0, 32'h8d25_0008, 32'h0040_0014, 32'h9, 32'hA,
                        5'd9, 5'd5, 5'd5, 1, 2'd3, 32'h0000_0007, 32'h4, 1, 2'd2));
    // Tnew=0 in E must give tnew_M=0 next cycle, not 3.
    applyStimulus(mkVec(0, 0, 32'had05_0000, 32'h0040_0018, 32'h1, 32'h2,
                        5'd8, 5'd5, 5'd0, 0, 2'd0, 32'h0000_0011, 32'hA, 0, 2'd0));
    // Stall and flush together for 3 cycles: one bubble per cycle.
    for (int i = 0; i < 3; i++)
      applyStimulus(mkVec(1, 1, 32'h0000_1234, 32'h0040_001C, 32'h1, 32'h1,
                          5'd1, 5'd2, 5'd3, 1, 2'd1, 32'(i + 1), 32'h2, 0, 2'd0));
    // Resume with two ALU ops.
    applyStimulus(mkVec(0, 0, 32'h0022_1821, 32'h0040_001C, 32'h10, 32'h20,
                        5'd1, 5'd2, 5'd3, 1, 2'd1, 32'h0, 32'h0, 1, 2'd1));
    applyStimulus(mkVec(0, 0, 32'h0064_2821, 32'h0040_0020, 32'h30, 32'h40,
                        5'd3, 5'd4, 5'd5, 1, 2'd1, 32'h30, 32'h20, 1, 2'd1));
    // Flush alone.
    applyStimulus(mkVec(0, 1, 32'h0064_2821, 32'h0040_0024, 32'h30, 32'h40,
                        5'd3, 5'd4, 5'd5, 1, 2'd2, 32'h70, 32'h40, 0, 2'd0));
    applyStimulus(mkVec(0, 0, 32'h8c06_0000, 32'h0040_0028, 32'h0, 32'h0,
                        5'd0, 5'd6, 5'd6, 1, 2'd2, 32'h0, 32'h0, 1, 2'd2));

    // Drive the counter into saturation, then keep stalling: stays FFFF.
    for (int i = 0; i < 65535; i++)
      applyStimulus(mkVec(1, 0, 32'h0, 32'h0040_002C, 32'h0, 32'h0,
                          5'd6, 5'd6, 5'd7, 1, 2'd1, 32'h0, 32'h0, 0, 2'd0));
    for (int i = 0; i < 3; i++)
      applyStimulus(mkVec(1, 0, 32'h0, 32'h0040_002C, 32'h0, 32'h0,
                          5'd6, 5'd6, 5'd7, 1, 2'd1, 32'h5, 32'h6, 0, 2'd0));
    applyStimulus(mkVec(0, 0, 32'h00c6_3821, 32'h0040_002C, 32'h8, 32'h8,
                        5'd6, 5'd6, 5'd7, 1, 2'd1, 32'h0, 32'h0, 1, 2'd1));

    // Mid-stream reset discards everything and clears the counter.
    v = mkVec(1, 0, 32'h00c6_3821, 32'h0040_0030, 32'h8, 32'h8,
              5'd6, 5'd6, 5'd7, 1, 2'd1, 32'h10, 32'h8, 0, 2'd0);
    v.rst_n = 1'b0;
    applyStimulus(v);
    applyStimulus(mkVec(0, 0, 32'h00e7_4021, 32'h0040_0034, 32'h9, 32'h9,
                        5'd7, 5'd7, 5'd8, 1, 2'd1, 32'h0, 32'h0, 1, 2'd1));
    applyStimulus(mkVec(0, 0, 32'h0, 32'h0040_0038, 32'h0, 32'h0,
                        5'd0, 5'd0, 5'd0, 0, 2'd0, 32'h12, 32'h9, 0, 2'd0));

    // Let the monitor drain the queue.
    repeat (2) @(negedge clk);
    #1;
    compared++;
    if (sb.size() != 0) begin
      mismatched++;
      $display("[TB] FAIL drain: got %0d pending expected 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/de_em_pipe.md
# de_em_pipe

Pipeline register pair between Decode→Execute and Execute→Memory in the 5-stage MIPS core. Carries each instruction's datapath payload and hazard metadata: register addresses, write enable, and the remaining-cycles-to-result countdown (Tnew). Its E and M outputs drive the stall/forward unit directly, so every field must be exact on every cycle. On a hazard stall it inserts a bubble into E while M keeps advancing.

## Interface
Parameters:
- DW, 32, datapath word width
- TW, 2, Tnew field width

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-low reset
- stall  in  1  from stall/forward unit; 1 = D held, bubble into E
- flush_e  in  1  1 = squash instruction entering E
- instr_d, pc_d, rs_d, rt_d  in  DW each  D-stage instruction, PC, RS/RT read data after D forwarding
- A1_D, A2_D, A3_D  in  5 each  rs, rt and destination register numbers
- regwrite_d  in  1  instruction writes GPR
- tnew_d  in  TW  cycles from E entry until the result exists (0..2)
- alu_e, rt_fwd_e  in  DW each  E-stage ALU result; forwarded RT store data
- instr_e, pc_e, rs_e, rt_e  out  DW each  E payload
- A1_E, A2_E, A3_E  out  5 each
- regwrite_e  out  1
- tnew_E  out  TW
- instr_m, pc_m, alu_m, rt_m  out  DW each  M payload
- A2_M, A3_M  out  5 each
- regwrite_m  out  1
- tnew_M  out  TW
- bubble_cnt  out  16  saturating count of bubbles inserted (perf counter)

## Operation
- D→E register update on each clock:
  - If stall or flush_e: load a bubble. instr=0 (nop), pc=pc_d, rs=rt=0, A1=A2=A3=0, regwrite=0, tnew=0.
  - Otherwise: load all D inputs.
  - tnew_d=3 is illegal. It is captured as 2.
  - regwrite_d with A3_D=0 is captured as regwrite_e=0.
- E→M register loads unconditionally every clock:
  - instr_m←instr_e, pc_m←pc_e, alu_m←alu_e, rt_m←rt_fwd_e, A2_M←A2_E, A3_M←A3_E, regwrite_m←regwrite_e.
  - tnew_M ← (tnew_E==0) ? 0 : tnew_E−1. This is a saturating decrement and never wraps to 3.
- bubble_cnt:
  - Increments by 1 on each clock where a bubble is loaded into E (stall|flush_e) and reset is high.
  - Saturates at 16'hFFFF.
- stall and flush_e together: a single bubble, counted once.
- No back-pressure into E/M. M-stage memory stalls are out of scope.

## Timing
- Reset (reset=0 at a rising edge):
  - Every output goes to 0 on that edge: all payload, all addresses, regwrite_e/m, tnew_E/M, bubble_cnt.
  - Reset overrides stall and flush_e.
  - Instructions in flight are discarded with no partial state.
- Latency: D inputs appear on E outputs 1 cycle later and on M outputs 2 cycles later.
- The stall is combinational from the current D/E contents. Its effect is registered: the bubble appears on E outputs the cycle after stall=1.
- A stalled instruction re-presented by D with stall=0 is captured normally.
- All outputs are registered. There are no combinational paths from inputs to outputs.

## Structure
- Shared package `mips_pkg` holds:
  - NOP_INSTR=32'h0
  - TNEW_MAX=2
  - Tnew encodings: TNEW_ALU=1 and TNEW_LOAD=2 at E entry, TNEW_NONE=0
  - REG_ZERO=5'd0
- One natural sub-module, `pipe_field_reg`: a parameterised-width register with synchronous active-low reset, load enable and clear-to-constant. It is instantiated for the D/E bundle (clear = stall|flush_e) and the E/M bundle (clear tied 0).
- The Tnew decrement and bubble_cnt logic live in the top.

## Test plan
- Reset: drive all inputs nonzero, reset=0 for 2 cycles → every output 0 and bubble_cnt=0. Release → first valid D instruction appears on E after 1 cycle.
- Load stall: present lw with A3_D=8, tnew_d=2, regwrite_d=1.
  - Next cycle: A3_E=8, tnew_E=2.
  - Following cycle with stall=1: E shows bubble (A3_E=0, regwrite_e=0, tnew_E=0); M shows A3_M=8, tnew_M=1, regwrite_m=1; bubble_cnt=1.
- Tnew countdown: addu with tnew_d=1 → tnew_E=1, then tnew_M=0. An instruction with tnew_d=0 gives tnew_M=0 (no wrap to 3).
- Zero-register write: regwrite_d=1, A3_D=0 → regwrite_e=0 and regwrite_m=0 on the subsequent cycles.
- Simultaneous stall=1 and flush_e=1 for 3 cycles → 3 bubbles in E, bubble_cnt=3. M receives the last real instruction, then zeros.
- Illegal tnew_d=3 → tnew_E=2, then tnew_M=1. Counter saturation: preload via 65 535 bubbles, then one more → bubble_cnt stays 16'hFFFF.
